// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback sources.
// The accepted write is registered and presented one cycle later. A saturating counter tracks contention.
module rf_wb_arbiter #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREQ = 3,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 stall,
    input  logic                 clr_stat,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic [IDW-1:0]       wr_src,
    output logic [15:0]          conflict_cnt
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] win_idx;
    logic [IDW:0]   cand;
    logic           found;
    logic           transfer;
    logic [AW-1:0]  win_addr;
    logic [DW-1:0]  win_data;
    logic           contention;

    // The candidate index is one bit wider than ptr so that ptr+k cannot overflow before the modulo wrap.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        transfer  = found && !stall;
        req_ready = '0;
        if (transfer) begin
            req_ready[win_idx] = 1'b1;
        end
        win_addr   = req_addr[win_idx*AW +: AW];
        win_data   = req_data[win_idx*DW +: DW];
        ptr_next   = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
        contention = $countones(req_valid) > 1;
    end

    // Writes to x0 still complete the handshake, but they never raise wr_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_src  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (transfer) begin
                wr_en   <= (win_addr != '0);
                wr_addr <= win_addr;
                wr_data <= win_data;
                wr_src  <= win_idx;
                ptr     <= ptr_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (clr_stat) begin
            conflict_cnt <= '0;
        end else if (contention && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter with three requesters.
// The expected values are computed by hand from the round-robin and output-register rules.
module tb_rf_wb_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREQ = 3;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                stall;
    logic                clr_stat;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic [IDW-1:0]      wr_src;
    logic [15:0]         conflict_cnt;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.DW(DW), .AW(AW), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .stall        (stall),
        .clr_stat     (clr_stat),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_src       (wr_src),
        .conflict_cnt (conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [NREQ-1:0] valid, input logic st, input logic clr);
        req_valid = valid;
        stall     = st;
        clr_stat  = clr;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_addr[i*AW +: AW] = addr;
        req_data[i*DW +: DW] = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NREQ-1:0] exp_rdy;
        int              src;

        rst_n    = 1'b0;
        req_addr = '0;
        req_data = '0;
        apply_stimulus(3'b111, 1'b0, 1'b0);
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), 32'hA000_0000 + DW'(i));

        // Two edges pass while reset is held with every requester valid
        #16;
        check_output("rst_wr_en", 64'(wr_en), 64'd0);
        check_output("rst_wr_addr", 64'(wr_addr), 64'd0);
        check_output("rst_wr_data", 64'(wr_data), 64'd0);
        check_output("rst_wr_src", 64'(wr_src), 64'd0);
        check_output("rst_conflict", 64'(conflict_cnt), 64'd0);
        rst_n = 1'b1;
        #1;

        for (int k = 0; k < 6; k++) begin
            src     = k % 3;
            exp_rdy = 3'b001 << src;
            check_output($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(exp_rdy));
            tick();
            check_output($sformatf("rr_wr_en_%0d", k), 64'(wr_en), 64'd1);
            check_output($sformatf("rr_wr_addr_%0d", k), 64'(wr_addr), 64'(src + 1));
            check_output($sformatf("rr_wr_data_%0d", k), 64'(wr_data), 64'(32'hA000_0000 + src));
            check_output($sformatf("rr_wr_src_%0d", k), 64'(wr_src), 64'(src));
        end
        check_output("rr_conflict", 64'(conflict_cnt), 64'd6);

        // Write to x0 from requester 1, pointer is back at 0
        set_req(1, 5'd0, 32'hDEADBEEF);
        apply_stimulus(3'b010, 1'b0, 1'b0);
        #1;
        check_output("x0_ready", 64'(req_ready), 64'b010);
        tick();
        check_output("x0_wr_en", 64'(wr_en), 64'd0);
        check_output("x0_wr_data", 64'(wr_data), 64'hDEADBEEF);
        check_output("x0_wr_src", 64'(wr_src), 64'd1);
        set_req(1, 5'd5, 32'h0000_0055);
        #1;
        check_output("x5_ready", 64'(req_ready), 64'b010);
        tick();
        check_output("x5_wr_en", 64'(wr_en), 64'd1);
        check_output("x5_wr_addr", 64'(wr_addr), 64'd5);
        check_output("x5_conflict", 64'(conflict_cnt), 64'd6);

        // Requester 2 accepted so that the pointer returns to 0
        set_req(2, 5'd7, 32'h0000_0077);
        apply_stimulus(3'b100, 1'b0, 1'b0);
        #1;
        check_output("p2_ready", 64'(req_ready), 64'b100);
        tick();
        check_output("p2_wr_addr", 64'(wr_addr), 64'd7);
        check_output("p2_wr_src", 64'(wr_src), 64'd2);

        set_req(0, 5'd9, 32'h0000_0099);
        set_req(2, 5'd10, 32'h0000_00AA);
        apply_stimulus(3'b101, 1'b1, 1'b0);
        #1;
        check_output("stall_wr_en_held", 64'(wr_en), 64'd1);
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("stall_ready_%0d", k), 64'(req_ready), 64'd0);
            tick();
            check_output($sformatf("stall_wr_en_%0d", k), 64'(wr_en), 64'd0);
        end
        check_output("stall_conflict", 64'(conflict_cnt), 64'd9);
        apply_stimulus(3'b101, 1'b0, 1'b0);
        #1;
        check_output("unstall_ready0", 64'(req_ready), 64'b001);
        tick();
        check_output("unstall_wr_addr0", 64'(wr_addr), 64'd9);
        apply_stimulus(3'b100, 1'b0, 1'b0);
        #1;
        check_output("unstall_ready2", 64'(req_ready), 64'b100);
        tick();
        check_output("unstall_wr_addr2", 64'(wr_addr), 64'd10);
        check_output("unstall_wr_src2", 64'(wr_src), 64'd2);
        check_output("unstall_conflict", 64'(conflict_cnt), 64'd10);

        // Saturation: clear, then count contended cycles up to the ceiling
        apply_stimulus(3'b111, 1'b1, 1'b1);
        tick();
        check_output("sat_clear", 64'(conflict_cnt), 64'd0);
        apply_stimulus(3'b111, 1'b1, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        check_output("sat_fffe", 64'(conflict_cnt), 64'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        check_output("sat_ffff", 64'(conflict_cnt), 64'hFFFF);
        apply_stimulus(3'b111, 1'b1, 1'b1);
        tick();
        check_output("sat_clr_prio", 64'(conflict_cnt), 64'd0);

        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), 32'hB000_0000 + DW'(i));
        apply_stimulus(3'b111, 1'b0, 1'b0);
        tick();
        tick();
        check_output("burst_wr_en", 64'(wr_en), 64'd1);
        check_output("burst_wr_addr", 64'(wr_addr), 64'd2);
        check_output("burst_conflict", 64'(conflict_cnt), 64'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("arst_wr_en", 64'(wr_en), 64'd0);
        check_output("arst_wr_addr", 64'(wr_addr), 64'd0);
        check_output("arst_wr_data", 64'(wr_data), 64'd0);
        check_output("arst_wr_src", 64'(wr_src), 64'd0);
        check_output("arst_conflict", 64'(conflict_cnt), 64'd0);
        rst_n = 1'b1;
        #1;
        check_output("arst_ptr_ready", 64'(req_ready), 64'b001);
        tick();
        check_output("arst_first_addr", 64'(wr_addr), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port among NREQ writeback sources: ALU, load unit, and mul/div/CSR.
- Uses a round-robin valid/ready handshake.
- The accepted write is registered and presented to the register file one cycle later.
- Sits between the execute/memory stages and the register file.
- Also keeps a saturating contention counter for performance debug.

Parameters:
- DW, 32: data width of a register write.
- AW, 5: register address width.
- NREQ, 3: number of writeback requesters, range 2..8.
- IDW, derived as $clog2(NREQ): width of the source-ID output.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NREQ  bit i = requester i has a write pending.
- req_addr  input  NREQ*AW  requester i address in bits [i*AW +: AW].
- req_data  input  NREQ*DW  requester i data in bits [i*DW +: DW].
- req_ready  output  NREQ  one-hot or zero; bit i = requester i accepted this cycle.
- stall  input  1  pipeline hold; blocks all acceptance.
- clr_stat  input  1  synchronous clear of conflict_cnt.
- wr_en  output  1  register-file write enable, registered.
- wr_addr  output  AW  register-file write address, registered.
- wr_data  output  DW  register-file write data, registered.
- wr_src  output  IDW  index of the requester that produced the current wr_* write.
- conflict_cnt  output  16  saturating count of cycles with two or more req_valid asserted.

Behaviour:
- Reset (rst_n=0, asynchronous): wr_en=0, wr_addr=0, wr_data=0, wr_src=0, conflict_cnt=0, round-robin pointer ptr=0. req_ready is combinational and is all-zero while stall or no valid.
- Arbitration (combinational):
  - Search indices ptr, ptr+1, ... mod NREQ; the first i with req_valid[i]=1 wins.
  - req_ready[i]=1 only for the winner, and only when stall=0.
  - At most one req_ready bit is set per cycle.
- Transfer: occurs on a rising edge where req_valid[i] & req_ready[i].
- Requester obligations: once req_valid is asserted, hold it and keep addr/data stable until accepted. The arbiter does not check this.
- Pointer update:
  - On transfer from i, ptr <= (i+1) mod NREQ.
  - With no transfer (including stall), ptr holds.
  - Result: a continuously requesting source waits at most NREQ-1 transfers.
- Output register, latency 1 cycle from the accept edge:
  - On a transfer, wr_addr <= req_addr[i], wr_data <= req_data[i], wr_src <= i.
  - wr_en <= 1, except when req_addr[i]==0: x0 writes are accepted (ready given) but wr_en <= 0.
  - With no transfer, wr_en <= 0 and wr_addr/wr_data/wr_src hold their last values.
  - wr_en is a one-cycle pulse per accepted write; back-to-back accepts give consecutive pulses.
- stall=1: no acceptance in that cycle; the previously registered write is still presented (wr_en pulse not suppressed).
- Single requester: granted every cycle it is valid and stall=0, giving full throughput (1 write/cycle).
- conflict_cnt:
  - Increments by 1 at each edge where popcount(req_valid) >= 2, regardless of stall.
  - Saturates at 16'hFFFF with no wrap.
  - clr_stat=1 sets it to 0 at the edge and takes priority over increment.
- Reset mid-operation: all registered state clears immediately; requests pending at reset are not written and must be re-presented.

Test Plan:
- Reset: hold rst_n=0 with req_valid=3'b111 -> wr_en=0, req_ready any value is ignored; after release, the first grant goes to req 0 (ptr=0), and wr_en=1 the next cycle with req_addr[0] and req_data[0].
- Round-robin: req_valid=3'b111 held for 6 cycles, addrs 1/2/3 -> req_ready sequence 001,010,100,001,010,100; wr_addr sequence 1,2,3,1,2,3 lagging one cycle; wr_src 0,1,2,0,1,2.
- x0 drop: req 1 only, addr=0, data=32'hDEADBEEF -> req_ready=3'b010 and the transfer completes, next cycle wr_en=0; then addr=5 -> wr_en=1, wr_addr=5.
- Stall: req_valid=3'b101 with stall=1 for 3 cycles -> req_ready=0, ptr unchanged, conflict_cnt +3; stall released -> req 0 granted first, then req 2.
- Counter saturation and clear: preload conflict_cnt to 16'hFFFE (force or 65534 contended cycles), 3 more contended cycles -> reads 16'hFFFF; clr_stat=1 together with contention -> 0.
- Async reset mid-burst: assert rst_n=0 between edges while wr_en=1 -> wr_en, wr_addr, wr_data and conflict_cnt drop to 0 without a clock edge; ptr returns to 0.
